onehot_demux_dispatch: RTL and testbench

- Inverse of the one-hot select mux: routes one input data stream to one of N outputs, chosen by a one-hot select that travels with the data.
- Each output has a 1-entry holding register and a valid/ready handshake, so a stalled consumer blocks only its own lane.
- Illegal selects (zero-hot or multi-hot) are dropped and counted.
- Sits between a single producer and N independent consumer lanes.

---
 rtl/onehot_demux_dispatch_if.sv | 23 ++
 rtl/onehot_demux_dispatch.sv | 63 ++++++
 tb/tb_onehot_demux_dispatch.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_demux_dispatch_if.sv
// rtl/onehot_demux_dispatch_if.sv - handshake bundle between producer, dispatcher and lane consumers
interface onehot_demux_dispatch_if #(
   parameter int N = 4,
   parameter int W = 2
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic [N-1:0]   in_sel;
   logic [N-1:0]   out_valid;
   logic [N-1:0]   out_ready;
   logic [N*W-1:0] out_data;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/onehot_demux_dispatch.sv
// rtl/onehot_demux_dispatch.sv - one-hot select demux into N single-entry lanes with illegal-select drop counter
module onehot_demux_dispatch #(
   parameter int N  = 4,
   parameter int W  = 2,
   parameter int CW = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   onehot_demux_dispatch_if.slave   bus,
   output logic [CW-1:0]            drop_cnt,
   output logic                     drop_err
);
   localparam logic [N-1:0]  SEL_ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [N-1:0]         full_q;
   logic [N-1:0][W-1:0]  data_q;
   logic [N-1:0]         lane_free;
   logic                 legal;
   logic                 accept;
   logic                 drop;

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   assign legal     = (bus.in_sel != '0) && ((bus.in_sel & (bus.in_sel - SEL_ONE)) == '0);
   assign lane_free = ~full_q | bus.out_ready;

   // Illegal words are always swallowed so a bad select can never wedge the producer.
   assign bus.in_ready = legal ? |(bus.in_sel & lane_free) : 1'b1;

   assign accept = bus.in_valid & bus.in_ready & legal;
   assign drop   = bus.in_valid & ~legal;

   assign bus.out_valid = full_q;
   assign bus.out_data  = data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= '0;
         data_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (accept && bus.in_sel[i]) begin
               full_q[i] <= 1'b1;
               data_q[i] <= bus.in_data;
            end else if (bus.out_ready[i]) begin
               full_q[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
         drop_err <= 1'b0;
      end else begin
         drop_err <= drop;
         if (drop && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_onehot_demux_dispatch.sv
// tb/tb_onehot_demux_dispatch.sv - self-checking bench for onehot_demux_dispatch
module tb_onehot_demux_dispatch;
   localparam int N   = 4;
   localparam int W   = 2;
   localparam int CW  = 8;
   localparam int CW2 = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [CW-1:0]  drop_cnt;
   logic           drop_err;
   logic [CW2-1:0] drop_cnt2;
   logic           drop_err2;

   always #5 clk = ~clk;

   onehot_demux_dispatch_if #(.N(N), .W(W)) bus ();
   onehot_demux_dispatch_if #(.N(N), .W(W)) bus2 ();

   // Second instance with a 2-bit counter sees identical traffic to exercise saturation.
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.in_data   = bus.in_data;
   assign bus2.in_sel    = bus.in_sel;
   assign bus2.out_ready = bus.out_ready;

   onehot_demux_dispatch #(.N(N), .W(W), .CW(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus), .drop_cnt(drop_cnt), .drop_err(drop_err)
   );

   onehot_demux_dispatch #(.N(N), .W(W), .CW(CW2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2), .drop_cnt(drop_cnt2), .drop_err(drop_err2)
   );

   int n_checks = 0;
   int n_fail   = 0;

   bit           m_full [N];
   logic [W-1:0] m_data [N];
   int           m_cnt;
   int           m_cnt2;
   bit           m_err;

   function automatic int sel_index(input logic [N-1:0] s);
      for (int i = 0; i < N; i++) if (s[i]) return i;
      return -1;
   endfunction

   function automatic bit model_ready();
      int idx;
      if ($countones(bus.in_sel) != 1) return 1'b1;
      idx = sel_index(bus.in_sel);
      return !m_full[idx] || bus.out_ready[idx];
   endfunction

   task automatic model_step();
      bit legal, rdy;
      int idx;
      legal = ($countones(bus.in_sel) == 1);
      rdy   = model_ready();
      idx   = sel_index(bus.in_sel);
      for (int i = 0; i < N; i++) if (bus.out_ready[i]) m_full[i] = 1'b0;
      if (bus.in_valid && rdy && legal) begin
         m_full[idx] = 1'b1;
         m_data[idx] = bus.in_data;
      end
      m_err = bus.in_valid && !legal;
      if (m_err) begin
         if (m_cnt < (1 << CW) - 1) m_cnt++;
         if (m_cnt2 < (1 << CW2) - 1) m_cnt2++;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_data = '0; bus.out_ready = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin m_full[i] = 1'b0; m_data[i] = '0; end
      m_cnt = 0; m_cnt2 = 0; m_err = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_sel = '0; bus.in_data = '0; bus.out_ready = '0;
      #12;
      n_checks++; if (bus.out_valid !== '0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
      n_checks++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
      n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop_err got=%b exp=0", drop_err); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_stream();
      logic [N-1:0] s;
      logic [W-1:0] d;
      apply_reset();
      bus.out_ready = '1;
      for (int k = 0; k < N; k++) begin
         s = '0; s[k] = 1'b1; d = W'(k);
         bus.in_valid = 1'b1; bus.in_sel = s; bus.in_data = d;
         #1;
         n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready lane=%0d got=%b exp=1", k, bus.in_ready); end
         @(posedge clk); #1;
         n_checks++; if (bus.out_valid !== s) begin n_fail++; $display("FAIL stream_out_valid lane=%0d got=%b exp=%b", k, bus.out_valid, s); end
         n_checks++; if (bus.out_data[k*W +: W] !== d) begin n_fail++; $display("FAIL stream_out_data lane=%0d got=%h exp=%h", k, bus.out_data[k*W +: W], d); end
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== '0) begin n_fail++; $display("FAIL stream_drain got=%b exp=0", bus.out_valid); end
      n_checks++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL stream_drop_cnt got=%0d exp=0", drop_cnt); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      bus.out_ready = 4'b1011;
      bus.in_valid = 1'b1; bus.in_sel = 4'b0100; bus.in_data = 2'b10;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready got=%b exp=1", bus.in_ready); end
      @(posedge clk); #1;
      bus.in_data = 2'b11;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_ready got=%b exp=0", bus.in_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.out_data[2*W +: W] !== 2'b10 || bus.out_valid !== 4'b0100) begin
         n_fail++; $display("FAIL bp_lane2_held got=%b/%h exp=0100/2", bus.out_valid, bus.out_data[2*W +: W]); end
      bus.in_sel = 4'b0001; bus.in_data = 2'b01;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_lane_ready got=%b exp=1", bus.in_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 4'b0101 || bus.out_data[0 +: W] !== 2'b01) begin
         n_fail++; $display("FAIL bp_other_lane got=%b/%h exp=0101/1", bus.out_valid, bus.out_data[0 +: W]); end
      bus.in_sel = 4'b0100; bus.in_data = 2'b11; bus.out_ready = 4'b1111;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain_refill_ready got=%b exp=1", bus.in_ready); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 4'b0100 || bus.out_data[2*W +: W] !== 2'b11) begin
         n_fail++; $display("FAIL bp_refill got=%b/%h exp=0100/3", bus.out_valid, bus.out_data[2*W +: W]); end
   endtask

   task automatic test_illegal();
      logic [N-1:0] sels [4];
      sels = '{4'b0000, 4'b0011, 4'b1010, 4'b1111};
      apply_reset();
      bus.out_ready = '1;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1; bus.in_sel = sels[k]; bus.in_data = W'(k);
         #1;
         n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready sel=%b got=%b exp=1", sels[k], bus.in_ready); end
         @(posedge clk); #1;
         n_checks++; if (bus.out_valid !== '0) begin n_fail++; $display("FAIL illegal_out_valid sel=%b got=%b exp=0", sels[k], bus.out_valid); end
         n_checks++; if (drop_cnt !== CW'(k + 1)) begin n_fail++; $display("FAIL illegal_drop_cnt got=%0d exp=%0d", drop_cnt, k + 1); end
         n_checks++; if (drop_err !== 1'b1) begin n_fail++; $display("FAIL illegal_drop_err got=%b exp=1", drop_err); end
      end
      bus.in_valid = 1'b0; bus.in_sel = 4'b0110;
      @(posedge clk); #1;
      n_checks++; if (drop_err !== 1'b0 || drop_cnt !== CW'(4)) begin
         n_fail++; $display("FAIL illegal_idle got=%b/%0d exp=0/4", drop_err, drop_cnt); end
   endtask

   task automatic test_saturation();
      int exp2 [5];
      exp2 = '{1, 2, 3, 3, 3};
      apply_reset();
      bus.out_ready = '1;
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = 1'b1; bus.in_sel = (k % 2 == 0) ? 4'b0000 : 4'b1100;
         @(posedge clk); #1;
         n_checks++; if (drop_cnt2 !== CW2'(exp2[k])) begin n_fail++; $display("FAIL sat_drop_cnt k=%0d got=%0d exp=%0d", k, drop_cnt2, exp2[k]); end
         n_checks++; if (drop_cnt !== CW'(k + 1)) begin n_fail++; $display("FAIL sat_wide_cnt k=%0d got=%0d exp=%0d", k, drop_cnt, k + 1); end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_async_reset();
      apply_reset();
      bus.out_ready = '0;
      bus.in_valid = 1'b1; bus.in_sel = 4'b0001; bus.in_data = 2'b01;
      @(posedge clk); #1;
      bus.in_sel = 4'b1000; bus.in_data = 2'b11;
      @(posedge clk); #1;
      bus.in_sel = 4'b0000;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 4'b1001 || drop_err !== 1'b1 || drop_cnt !== CW'(1)) begin
         n_fail++; $display("FAIL arst_preload got=%b/%b/%0d exp=1001/1/1", bus.out_valid, drop_err, drop_cnt); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (bus.out_valid !== '0) begin n_fail++; $display("FAIL arst_out_valid got=%b exp=0", bus.out_valid); end
      n_checks++; if (drop_cnt !== '0 || drop_cnt2 !== '0) begin n_fail++; $display("FAIL arst_drop_cnt got=%0d/%0d exp=0", drop_cnt, drop_cnt2); end
      n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL arst_drop_err got=%b exp=0", drop_err); end
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      bus.out_ready = '1; bus.in_valid = 1'b1; bus.in_sel = 4'b0010; bus.in_data = 2'b10;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_after_ready got=%b exp=1", bus.in_ready); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 4'b0010 || bus.out_data[W +: W] !== 2'b10) begin
         n_fail++; $display("FAIL arst_after_word got=%b/%h exp=0010/2", bus.out_valid, bus.out_data[W +: W]); end
   endtask

   task automatic test_random();
      bit             hold;
      bit             exp_rdy;
      logic [N-1:0]   s;
      logic [N-1:0]   exp_valid;
      logic [N*W-1:0] exp_data;
      apply_reset();
      hold = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!hold) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) != 0) begin
               s = '0; s[$urandom_range(0, N - 1)] = 1'b1;
            end else begin
               s = N'($urandom);
            end
            bus.in_sel  = s;
            bus.in_data = W'($urandom);
         end
         bus.out_ready = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
         #1;
         exp_rdy = model_ready();
         n_checks++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, exp_rdy); end
         hold = bus.in_valid && !exp_rdy;
         model_step();
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            exp_valid[i] = m_full[i];
            exp_data[i*W +: W] = m_data[i];
         end
         n_checks++; if (bus.out_valid !== exp_valid) begin n_fail++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", c, bus.out_valid, exp_valid); end
         n_checks++; if (bus.out_data !== exp_data) begin n_fail++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", c, bus.out_data, exp_data); end
         n_checks++; if (drop_cnt !== CW'(m_cnt) || drop_cnt2 !== CW2'(m_cnt2)) begin
            n_fail++; $display("FAIL rand_drop_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", c, drop_cnt, drop_cnt2, m_cnt, m_cnt2); end
         n_checks++; if (drop_err !== m_err || drop_err2 !== m_err) begin
            n_fail++; $display("FAIL rand_drop_err cyc=%0d got=%b/%b exp=%b", c, drop_err, drop_err2, m_err); end
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_illegal();
      test_saturation();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
